mu0_control: RTL and testbench



---
 rtl/mu0_pkg.sv | 47 ++++
 rtl/mu0_decode.sv | 78 +++++++
 rtl/mu0_control.sv | 108 ++++++++++
 tb/tb_mu0_control.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control path: opcodes, ALU function codes,
// sequencer state encoding and the raw (ungated) control bundle produced by
// mu0_decode.
package mu0_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec  = 2'b01,
    StHalt  = 2'b10
  } state_e;

  // Opcodes, IR[15:12]
  localparam logic [3:0] OpLda = 4'd0;
  localparam logic [3:0] OpSta = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpJmp = 4'd4;
  localparam logic [3:0] OpJge = 4'd5;
  localparam logic [3:0] OpJne = 4'd6;
  localparam logic [3:0] OpStp = 4'd7;

  // ALU function codes
  localparam logic [1:0] AluPassY = 2'b00;
  localparam logic [1:0] AluAdd   = 2'b01;
  localparam logic [1:0] AluSub   = 2'b10;
  localparam logic [1:0] AluInc   = 2'b11;

  // Control set before MemRdy / reset gating
  typedef struct packed {
    logic       asel;
    logic       ysel;
    logic [1:0] alufs;
    logic       pcsel;
    logic       pc_ce;
    logic       ir_ce;
    logic       acc_ce;
    logic       acc_oe;
    logic       mem_rq;
    logic       rnw;
  } ctrl_t;

  // LDA, STA, ADD and SUB are the only opcodes that touch memory in EXEC
  function automatic logic is_mem_op(input logic [3:0] f);
    return (f[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/mu0_decode.sv
// Combinational decode of sequencer state, opcode and accumulator flags into
// the raw control set. Register enables of memory cycles are returned
// ungated; mu0_control qualifies them with MemRdy.
// Ports:
//   state  current sequencer state
//   f      opcode IR[15:12]
//   n, z   accumulator negative / zero flags
//   ctrl   raw control bundle
module mu0_decode
  import mu0_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] f,
  input  logic       n,
  input  logic       z,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = '0;
    ctrl.rnw   = 1'b1;
    ctrl.alufs = AluPassY;
    unique case (state)
      StFetch: begin
        ctrl.asel   = 1'b0;
        ctrl.mem_rq = 1'b1;
        ctrl.ysel   = 1'b0;
        ctrl.alufs  = AluInc;
        ctrl.pcsel  = 1'b0;
        ctrl.ir_ce  = 1'b1;
        ctrl.pc_ce  = 1'b1;
      end
      StExec: begin
        ctrl.asel = 1'b1;
        case (f)
          OpLda: begin
            ctrl.mem_rq = 1'b1;
            ctrl.ysel   = 1'b1;
            ctrl.alufs  = AluPassY;
            ctrl.acc_ce = 1'b1;
          end
          OpSta: begin
            ctrl.mem_rq = 1'b1;
            ctrl.rnw    = 1'b0;
            ctrl.acc_oe = 1'b1;
          end
          OpAdd: begin
            ctrl.mem_rq = 1'b1;
            ctrl.ysel   = 1'b1;
            ctrl.alufs  = AluAdd;
            ctrl.acc_ce = 1'b1;
          end
          OpSub: begin
            ctrl.mem_rq = 1'b1;
            ctrl.ysel   = 1'b1;
            ctrl.alufs  = AluSub;
            ctrl.acc_ce = 1'b1;
          end
          OpJmp: begin
            ctrl.pcsel = 1'b1;
            ctrl.pc_ce = 1'b1;
          end
          OpJge: begin
            ctrl.pcsel = 1'b1;
            ctrl.pc_ce = ~n;
          end
          OpJne: begin
            ctrl.pcsel = 1'b1;
            ctrl.pc_ce = ~z;
          end
          default: ;  // STP and 8-15 assert nothing
        endcase
      end
      default: ;  // StHalt: everything idle, address mux on PC
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer. Drives the address mux select, register clock
// enables, ALU function, PC source and the memory request handshake. A memory
// request left waiting for MEM_TIMEOUT+1 cycles halts the machine with a
// sticky Fault.
// Ports:
//   Clk, nReset              clock, asynchronous active-low reset
//   F, N, Z                  opcode and accumulator flags
//   MemRdy                   memory completes the current request
//   Asel, Ysel, ALUfs, PCsel datapath steering
//   PCce, IRce, ACCce        register enables
//   ACCoe, MemRq, RnW        memory interface
//   Halted, Fault            status
module mu0_control
  import mu0_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       MemRdy,
  output logic       Asel,
  output logic       Ysel,
  output logic [1:0] ALUfs,
  output logic       PCsel,
  output logic       PCce,
  output logic       IRce,
  output logic       ACCce,
  output logic       ACCoe,
  output logic       MemRq,
  output logic       RnW,
  output logic       Halted,
  output logic       Fault
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wcnt_q, wcnt_d;
  logic            fault_q, fault_d;
  ctrl_t           ctrl;
  logic            en_ok;

  mu0_decode u_decode (
    .state (state_q),
    .f     (F),
    .n     (N),
    .z     (Z),
    .ctrl  (ctrl)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= StFetch;
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fault_d = fault_q;
    if (ctrl.mem_rq && !MemRdy) begin
      // MemRdy on the timeout cycle wins, so only a still-pending request faults
      if (wcnt_q == TO_W'(MEM_TIMEOUT)) begin
        state_d = StHalt;
        fault_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + TO_W'(1);
      end
    end else begin
      unique case (state_q)
        StFetch: state_d = StExec;
        StExec:  state_d = (F == OpStp) ? StHalt : StFetch;
        StHalt:  state_d = StHalt;
        default: state_d = StFetch;
      endcase
    end
    if (state_d != state_q) begin
      wcnt_d = '0;
    end
  end

  always_comb begin
    // Enables of a memory cycle only fire when the access completes
    en_ok  = ctrl.mem_rq ? MemRdy : 1'b1;
    // Reset gating is combinational so a mid-access reset drops the request at once
    Asel   = nReset & ctrl.asel;
    Ysel   = ctrl.ysel;
    ALUfs  = ctrl.alufs;
    PCsel  = ctrl.pcsel;
    PCce   = nReset & ctrl.pc_ce & en_ok;
    IRce   = nReset & ctrl.ir_ce & en_ok;
    ACCce  = nReset & ctrl.acc_ce & en_ok;
    ACCoe  = nReset & ctrl.acc_oe;
    MemRq  = nReset & ctrl.mem_rq;
    RnW    = ~nReset | ctrl.rnw;
    Halted = (state_q == StHalt);
    Fault  = fault_q;
  end

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: a reference model predicts the control
// outputs for each cycle, pushes them to a scoreboard queue, and a monitor
// compares them against the DUT on the falling edge.
module tb_mu0_control;

  localparam int TO = 15;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [3:0] F;
  logic       N, Z, MemRdy;
  logic       Asel, Ysel, PCsel, PCce, IRce, ACCce, ACCoe, MemRq, RnW, Halted, Fault;
  logic [1:0] ALUfs;

  always #5 Clk = ~Clk;

  mu0_control #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .F      (F),
    .N      (N),
    .Z      (Z),
    .MemRdy (MemRdy),
    .Asel   (Asel),
    .Ysel   (Ysel),
    .ALUfs  (ALUfs),
    .PCsel  (PCsel),
    .PCce   (PCce),
    .IRce   (IRce),
    .ACCce  (ACCce),
    .ACCoe  (ACCoe),
    .MemRq  (MemRq),
    .RnW    (RnW),
    .Halted (Halted),
    .Fault  (Fault)
  );

  typedef struct packed {
    logic       asel;
    logic       ysel;
    logic [1:0] alufs;
    logic       pcsel;
    logic       pcce;
    logic       irce;
    logic       accce;
    logic       accoe;
    logic       memrq;
    logic       rnw;
    logic       halted;
    logic       fault;
  } out_t;

  typedef struct {
    out_t  val;
    out_t  care;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: machine phase, waiting cycles, sticky fault
  localparam int PhFetch = 0;
  localparam int PhExec  = 1;
  localparam int PhHalt  = 2;
  int m_ph    = PhFetch;
  int m_wait  = 0;
  bit m_fault = 1'b0;

  function automatic bit model_mem_busy(input logic [3:0] f);
    return (m_ph == PhFetch) || (m_ph == PhExec && f < 4);
  endfunction

  function automatic void model_out(input logic [3:0] f, input logic n, input logic z,
                                    input logic rdy, output out_t v, output out_t c);
    v = '0;
    c = '0;
    v.rnw = 1'b1;
    // Always-specified fields
    c.asel = 1; c.pcce = 1; c.irce = 1; c.accce = 1; c.accoe = 1; c.memrq = 1;
    c.halted = 1; c.fault = 1;
    if (!nReset) begin
      c.rnw = 1;
      return;
    end
    v.fault  = m_fault;
    v.halted = (m_ph == PhHalt);
    if (m_ph == PhFetch) begin
      c.rnw = 1; c.ysel = 1; c.alufs = '1; c.pcsel = 1;
      v.memrq = 1; v.alufs = 2'b11; v.irce = rdy; v.pcce = rdy;
    end else if (m_ph == PhExec) begin
      v.asel = 1;
      if (f < 4) begin
        c.rnw   = 1;
        v.memrq = 1;
        v.rnw   = (f != 1);
        v.accoe = (f == 1);
        if (f != 1) begin
          c.ysel = 1; c.alufs = '1;
          v.ysel  = 1;
          v.alufs = (f == 0) ? 2'b00 : (f == 2) ? 2'b01 : 2'b10;
          v.accce = rdy;
        end
      end else if (f < 7) begin
        c.pcsel = 1;
        v.pcsel = 1;
        v.pcce  = (f == 4) ? 1'b1 : (f == 5) ? ~n : ~z;
      end
    end
  endfunction

  function automatic void model_step(input logic [3:0] f, input logic rdy);
    if (!nReset) begin
      m_ph = PhFetch; m_wait = 0; m_fault = 0;
    end else if (model_mem_busy(f) && !rdy) begin
      if (m_wait == TO) begin
        m_ph = PhHalt; m_wait = 0; m_fault = 1;
      end else begin
        m_wait++;
      end
    end else if (m_ph == PhFetch) begin
      m_ph = PhExec; m_wait = 0;
    end else if (m_ph == PhExec) begin
      m_ph = (f == 7) ? PhHalt : PhFetch; m_wait = 0;
    end
  endfunction

  // Apply one cycle of inputs, predict, then advance the model on the edge
  task automatic drive(input logic [3:0] f, input logic n, input logic z, input logic rdy,
                       input string name);
    exp_t e;
    F = f; N = n; Z = z; MemRdy = rdy;
    model_out(f, n, z, rdy, e.val, e.care);
    e.name = name;
    sb_q.push_back(e);
    @(posedge Clk);
    model_step(f, rdy);
    #1;
  endtask

  always @(negedge Clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      out_t got;
      e   = sb_q.pop_front();
      got = {Asel, Ysel, ALUfs, PCsel, PCce, IRce, ACCce, ACCoe, MemRq, RnW, Halted, Fault};
      checks++;
      if (((got ^ e.val) & e.care) != '0) begin
        errors++;
        $display("FAIL %s @%0t: got %b required %b (care %b)", e.name, $time, got, e.val,
                 e.care);
      end
    end
  end

  initial begin
    int mode;
    logic r;
    nReset = 1'b0; F = '0; N = 0; Z = 0; MemRdy = 0;
    @(posedge Clk);
    #1;
    drive(4'd0, 0, 0, 1, "reset_hold");
    drive(4'd0, 0, 0, 1, "reset_hold");
    nReset = 1'b1;

    // LDA with memory always ready
    drive(4'd0, 0, 0, 1, "lda_fetch");
    drive(4'd0, 0, 0, 1, "lda_exec");
    drive(4'd0, 0, 0, 1, "lda_refetch");
    drive(4'd1, 0, 0, 1, "sta_exec_fast");
    // STA stalled 3 cycles
    drive(4'd1, 0, 0, 1, "sta_fetch");
    for (int i = 0; i < 3; i++) drive(4'd1, 0, 0, 0, "sta_wait");
    drive(4'd1, 0, 0, 1, "sta_done");
    // JGE with N=1 then N=0
    drive(4'd5, 1, 0, 1, "jge_fetch");
    drive(4'd5, 1, 0, 0, "jge_n1");
    drive(4'd5, 0, 0, 1, "jge_fetch2");
    drive(4'd5, 0, 0, 0, "jge_n0");
    drive(4'd6, 0, 1, 1, "jne_fetch");
    drive(4'd6, 0, 1, 1, "jne_z1");
    drive(4'd9, 0, 0, 1, "nop_fetch");
    drive(4'd9, 0, 0, 1, "nop_exec");
    // STP then idle with MemRdy toggling
    drive(4'd7, 0, 0, 1, "stp_fetch");
    drive(4'd7, 0, 0, 1, "stp_exec");
    for (int i = 0; i < 20; i++) drive(4'($urandom_range(0, 15)), 0, 0, 1'(i), "halted");
    nReset = 1'b0;
    drive(4'd0, 0, 0, 1, "reset_from_halt");
    nReset = 1'b1;
    // FETCH timeout: 16 waiting cycles then halt with fault
    for (int i = 0; i < 16; i++) drive(4'd0, 0, 0, 0, "fetch_wait");
    for (int i = 0; i < 3; i++) drive(4'd0, 0, 0, 1, "fault_halt");
    nReset = 1'b0;
    drive(4'd0, 0, 0, 0, "reset_clears_fault");
    nReset = 1'b1;
    // MemRdy on the last permitted cycle wins
    for (int i = 0; i < 15; i++) drive(4'd2, 0, 0, 0, "fetch_wait_late");
    drive(4'd2, 0, 0, 1, "fetch_late_ready");
    drive(4'd2, 0, 0, 1, "add_exec");
    // Asynchronous reset mid fetch wait, checked before any rising edge
    for (int i = 0; i < 5; i++) drive(4'd3, 0, 0, 0, "fetch_wait_pre_rst");
    nReset = 1'b0;
    drive(4'd3, 0, 0, 0, "async_reset");
    nReset = 1'b1;
    for (int i = 0; i < 15; i++) drive(4'd3, 0, 0, 0, "wait_after_rst");
    drive(4'd3, 0, 0, 1, "ready_after_rst");

    // Randomized traffic with varying memory latency
    mode = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = ($urandom_range(0, 19) == 0);
      endcase
      if ((m_ph == PhHalt && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0)
        nReset = 1'b0;
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r,
            "random");
      nReset = 1'b1;
    end

    repeat (3) @(posedge Clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
